input_port16: RTL and testbench

//  - Read-side I/O peripheral for the cpu16 system: conditions the board switches and

---
 rtl/input_port16_pkg.sv | 27 ++
 rtl/input_port16_if.sv | 12 +
 rtl/input_port16_debounce.sv | 51 +++++
 rtl/input_port16.sv | 92 +++++++++
 tb/tb_input_port16.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/input_port16_pkg.sv
// Shared definitions for the input_port16 read-side peripheral: register map and read mux.
// Used by the block itself, CPU-side address decode and the bench.
package input_port16_pkg;

   typedef logic [1:0] ip_addr_t;

   localparam ip_addr_t IP_ADDR_SW       = 2'd0;
   localparam ip_addr_t IP_ADDR_BTN      = 2'd1;
   localparam ip_addr_t IP_ADDR_PRESSED  = 2'd2;
   localparam ip_addr_t IP_ADDR_RELEASED = 2'd3;

   function automatic logic [15:0] ip_read_mux(input ip_addr_t   addr,
                                               input logic [15:0] sw,
                                               input logic [15:0] lvl,
                                               input logic [15:0] prs,
                                               input logic [15:0] rel);
      logic [15:0] r;
      unique case (addr)
         IP_ADDR_SW:      r = sw;
         IP_ADDR_BTN:     r = lvl;
         IP_ADDR_PRESSED: r = prs;
         default:         r = rel;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/input_port16_if.sv
// CPU-side register bus of input_port16: address, read strobe, read data and interrupt.
interface input_port16_if;
   import input_port16_pkg::*;

   ip_addr_t    addr;
   logic        rd;
   logic [15:0] dout;
   logic        irq;

   modport master (output addr, rd, input dout, irq);
   modport slave  (input addr, rd, output dout, irq);
endinterface

// File: rtl/input_port16_debounce.sv
// One pushbutton: two-flop synchronizer, stability counter and accepted level.
// rise_o/fall_o pulse in the cycle the level is updated, so events latch on the same edge.
module input_port16_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q, sync_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   always_comb begin
      accept  = (sync_q != level_q) && (cnt_q == CNT_LAST);
      cnt_d   = '0;
      level_d = level_q;
      if (accept) begin
         level_d = sync_q;
      end else if (sync_q != level_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = accept &  sync_q;
   assign fall_o  = accept & ~sync_q;

endmodule

// File: rtl/input_port16.sv
// Read-side I/O peripheral: synchronized switches, debounced buttons, sticky press/release events.
// Optional INPUT_PORT_IRQ_EN drives irq from any pending press; otherwise irq is tied low.
module input_port16
   import input_port16_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int NUM_BUTTONS     = 5,
   parameter int SW_WIDTH        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SW_WIDTH-1:0]    switches,
   input  logic [NUM_BUTTONS-1:0] buttons,
   input_port16_if.slave          bus
);

   logic [SW_WIDTH-1:0]    sw_meta_q, sw_sync_q;
   logic [NUM_BUTTONS-1:0] btn_level, btn_rise, btn_fall;
   logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
   logic [NUM_BUTTONS-1:0] released_q, released_d;
   logic [15:0]            dout_q, dout_d;
   logic [15:0]            sw_ext, lvl_ext, prs_ext, rel_ext;
   logic                   clr_prs, clr_rel;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      input_port16_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .btn_i  (buttons[i]),
         .level_o(btn_level[i]),
         .rise_o (btn_rise[i]),
         .fall_o (btn_fall[i])
      );
   end

   always_comb begin
      sw_ext  = '0;
      lvl_ext = '0;
      prs_ext = '0;
      rel_ext = '0;
      sw_ext[SW_WIDTH-1:0]     = sw_sync_q;
      lvl_ext[NUM_BUTTONS-1:0] = btn_level;
      prs_ext[NUM_BUTTONS-1:0] = pressed_q;
      rel_ext[NUM_BUTTONS-1:0] = released_q;

      clr_prs = bus.rd && (bus.addr == IP_ADDR_PRESSED);
      clr_rel = bus.rd && (bus.addr == IP_ADDR_RELEASED);

      // Clear first, then OR in new events: a same-cycle event survives the read.
      pressed_d  = (clr_prs ? '0 : pressed_q)  | btn_rise;
      released_d = (clr_rel ? '0 : released_q) | btn_fall;

      dout_d = bus.rd ? ip_read_mux(bus.addr, sw_ext, lvl_ext, prs_ext, rel_ext) : dout_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         dout_q     <= '0;
      end else begin
         sw_meta_q  <= switches;
         sw_sync_q  <= sw_meta_q;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         dout_q     <= dout_d;
      end
   end

   assign bus.dout = dout_q;

`ifdef INPUT_PORT_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |pressed_q;
      end
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_input_port16.sv
// Scoreboard bench for input_port16 at DEBOUNCE_CYCLES=4: reads queue expectations, a monitor checks dout.
module tb_input_port16;
   import input_port16_pkg::*;

`ifdef INPUT_PORT_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] switches;
   logic [4:0]  buttons;

   always #1 clk = ~clk;

   input_port16_if bus();

   input_port16 #(
      .DEBOUNCE_CYCLES(4),
      .NUM_BUTTONS    (5),
      .SW_WIDTH       (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .switches(switches),
      .buttons (buttons),
      .bus     (bus)
   );

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t sbq[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle read strobe; the expected dout is queued for the monitor.
   task automatic rd_reg(input ip_addr_t a, input logic [15:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.val  = exp;
      sbq.push_back(e);
      bus.addr = a;
      bus.rd   = 1'b1;
      @(negedge clk);
      bus.rd   = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         if (bus.rd === 1'b1 && reset === 1'b0) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_read: got %h expected no read", bus.dout);
            end else begin
               e = sbq.pop_front();
               chk(e.name, bus.dout, e.val);
            end
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.rd   = 1'b0;
      bus.addr = IP_ADDR_SW;
      reset    = 1'b1;
      buttons  = 5'h1F;
      switches = 16'hFFFF;

      @(negedge clk);
      chk("reset_dout_e1", bus.dout, 16'h0000);
      chk("reset_irq_e1", {15'b0, bus.irq}, 16'h0000);
      @(negedge clk);
      chk("reset_dout_e2", bus.dout, 16'h0000);
      chk("reset_irq_e2", {15'b0, bus.irq}, 16'h0000);

      reset    = 1'b0;
      buttons  = 5'h00;
      switches = 16'h1234;
      idle(3);
      rd_reg(IP_ADDR_SW, 16'h1234, "sw_1234");
      rd_reg(IP_ADDR_PRESSED, 16'h0000, "no_press_after_reset");

      switches = 16'hA5C3;
      idle(2);
      rd_reg(IP_ADDR_SW, 16'hA5C3, "sw_a5c3");

      // Clean press of button 2: level must flip on exactly the 6th edge.
      buttons[2] = 1'b1;
      idle(5);
      rd_reg(IP_ADDR_BTN, 16'h0000, "lvl_after_edge5");
      rd_reg(IP_ADDR_BTN, 16'h0004, "lvl_after_edge6");
      rd_reg(IP_ADDR_PRESSED, 16'h0004, "pressed_b2");
      rd_reg(IP_ADDR_PRESSED, 16'h0000, "pressed_b2_cleared");
      rd_reg(IP_ADDR_RELEASED, 16'h0000, "released_none");

      // Bounce on button 1, then a steady hold.
      for (int k = 0; k < 6; k++) begin
         buttons[1] = (k % 2 == 0);
         idle(2);
      end
      buttons[1] = 1'b1;
      idle(4);
      rd_reg(IP_ADDR_PRESSED, 16'h0000, "bounce_no_event");
      idle(1);
      rd_reg(IP_ADDR_PRESSED, 16'h0002, "bounce_pressed_b1");
      rd_reg(IP_ADDR_PRESSED, 16'h0000, "bounce_pressed_once");
      rd_reg(IP_ADDR_BTN, 16'h0006, "lvl_b1_b2");

      // Release of button 2 collides with a read of the released register.
      buttons[2] = 1'b0;
      idle(5);
      rd_reg(IP_ADDR_RELEASED, 16'h0000, "rel_collide_snapshot");
      rd_reg(IP_ADDR_RELEASED, 16'h0004, "rel_b2_survived");
      rd_reg(IP_ADDR_RELEASED, 16'h0000, "rel_b2_cleared");
      rd_reg(IP_ADDR_BTN, 16'h0002, "lvl_b1_only");

      // Interrupt: pressed[0] sets on edge 6, irq follows on edge 7.
      buttons[0] = 1'b1;
      idle(6);
      chk("irq_before", {15'b0, bus.irq}, 16'h0000);
      idle(1);
      chk("irq_raised", {15'b0, bus.irq}, {15'b0, IRQ_ON});
      rd_reg(IP_ADDR_PRESSED, 16'h0001, "pressed_b0");
      chk("irq_read_edge", {15'b0, bus.irq}, {15'b0, IRQ_ON});
      idle(1);
      chk("irq_dropped", {15'b0, bus.irq}, 16'h0000);

      idle(2);
      chk("scoreboard_drained", 16'(sbq.size()), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
